// File: rtl/int_to_e4m3_encoder.sv
// Iterative signed-integer to E4M3 converter: one normalising shift per clock,
// then round-to-nearest-even with saturation to the largest finite code.
module int_to_e4m3_encoder #(
    parameter int IN_W = 16,
    parameter int BIAS = 7
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic            out_ovf
);
    localparam int EXP_W = 8;
    localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(BIAS + IN_W - 1);
    localparam logic [IN_W-2:0]  ST_MASK  = (IN_W-1)'((64'd1 << (IN_W - 5)) - 64'd1);

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic [IN_W-1:0]   mag_q, mag_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_ovf_q, out_ovf_d;

    // Operates on the bits below the hidden leading one; returns {ovf, code}.
    function automatic logic [8:0] round_pack(input logic             s,
                                              input logic [IN_W-2:0]  frac,
                                              input logic [EXP_W-1:0] e_in);
        logic [3:0]       m_ext;
        logic             g, st, up;
        logic [EXP_W-1:0] e;
        logic [8:0]       res;
        m_ext = {1'b0, frac[IN_W-2 -: 3]};
        g     = frac[IN_W-5];
        st    = |(frac & ST_MASK);
        up    = g & (st | m_ext[0]);
        m_ext = m_ext + {3'b000, up};
        e     = e_in + {{(EXP_W-1){1'b0}}, m_ext[3]};
        if (e > EXP_W'(15))
            res = {1'b1, s, 7'h7F};
        else
            res = {1'b0, s, e[3:0], m_ext[2:0]};
        return res;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            out_data_q <= 8'h00;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        sign_q <= sign_d;
        mag_q  <= mag_d;
        exp_q  <= exp_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_NORM;
            S_NORM: begin
                if (mag_q == '0)          state_d = S_DONE;
                else if (mag_q[IN_W-1])   state_d = S_ROUND;
            end
            S_ROUND: state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sign_d     = sign_q;
        mag_d      = mag_q;
        exp_d      = exp_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d = in_data[IN_W-1];
                    mag_d  = in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;
                    exp_d  = EXP_INIT;
                end
            end
            S_NORM: begin
                // Zero drops the sign so -0 is never emitted.
                if (mag_q == '0) begin
                    out_data_d = 8'h00;
                    out_ovf_d  = 1'b0;
                end else if (!mag_q[IN_W-1]) begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - EXP_W'(1);
                end
            end
            S_ROUND: {out_ovf_d, out_data_d} = round_pack(sign_q, mag_q[IN_W-2:0], exp_q);
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    assign out_data = out_data_q;
    assign out_ovf  = out_ovf_q;
endmodule

// File: tb/tb_int_to_e4m3_encoder.sv
// Scoreboard bench for int_to_e4m3_encoder with hand-computed directed vectors.
module tb_int_to_e4m3_encoder;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_ovf;

    int_to_e4m3_encoder #(.IN_W(16), .BIAS(7)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] d;
        logic       o;
        int         lat;
        int         acc;
        string      nm;
    } item_t;

    item_t sb[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    logic  seen  = 1'b0;
    int    first_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Monitor: pops an expectation on every output handshake.
    initial begin
        item_t it;
        forever begin
            @(negedge clock);
            #2;
            if (out_valid && !seen) begin
                seen      = 1'b1;
                first_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %0h want none", out_data);
                end else begin
                    it = sb.pop_front();
                    chk({it.nm, "_data"}, {24'h0, out_data}, {24'h0, it.d});
                    chk({it.nm, "_ovf"}, {31'h0, out_ovf}, {31'h0, it.o});
                    chk({it.nm, "_lat"}, first_cyc - it.acc + 1, it.lat);
                end
                seen = 1'b0;
            end
            if (!out_valid) seen = 1'b0;
        end
    end

    task automatic send(input string nm, input logic [15:0] v, input logic [7:0] ed,
                        input logic eo, input int lat);
        item_t it;
        int n;
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = v;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL %s_accept: got in_ready=0 want 1", nm);
            in_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        it.d = ed; it.o = eo; it.lat = lat; it.acc = cyc; it.nm = nm;
        sb.push_back(it);
        @(negedge clock);
        in_valid = 1'b0;
        in_data  = 16'h5555;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk({nm, "_drain"}, sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_in_ready", {31'h0, in_ready}, 1);
        chk("rst_out_valid", {31'h0, out_valid}, 0);
        chk("rst_out_data", {24'h0, out_data}, 0);
        chk("rst_out_ovf", {31'h0, out_ovf}, 0);
        reset = 1'b0;

        send("one", 16'h0001, 8'h38, 1'b0, 18);        drain("one");
        send("neg3", 16'hFFFD, 8'hC4, 1'b0, 17);       drain("neg3");
        send("zero", 16'h0000, 8'h00, 1'b0, 2);        drain("zero");
        send("negzero", -16'sd0, 8'h00, 1'b0, 2);      drain("negzero");
        send("r17", 16'd17, 8'h58, 1'b0, 14);          drain("r17");
        send("r19", 16'd19, 8'h5A, 1'b0, 14);          drain("r19");
        send("r460", 16'd460, 8'h7E, 1'b0, 10);        drain("r460");
        send("r470", 16'd470, 8'h7F, 1'b0, 10);        drain("r470");
        send("r500", 16'd500, 8'h7F, 1'b1, 10);        drain("r500");
        send("min", 16'h8000, 8'hFF, 1'b1, 3);         drain("min");
        send("max", 16'h7FFF, 8'h7F, 1'b1, 4);         drain("max");

        // Backpressure: hold the result, poke in_valid while busy.
        out_ready = 1'b0;
        send("bp", 16'd19, 8'h5A, 1'b0, 14);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("bp_valid_seen", {31'h0, out_valid}, 1);
        in_valid = 1'b1;
        in_data  = 16'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            #1;
            chk("bp_hold_data", {24'h0, out_data}, 32'h5A);
            chk("bp_in_ready", {31'h0, in_ready}, 0);
            chk("bp_out_valid", {31'h0, out_valid}, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("bp");
        repeat (20) @(negedge clock);
        send("after_bp", 16'd3, 8'h44, 1'b0, 17);      drain("after_bp");

        // Reset mid-NORM discards the conversion.
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = 16'd1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midrst_in_ready", {31'h0, in_ready}, 1);
        chk("midrst_out_valid", {31'h0, out_valid}, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (25) @(negedge clock);
        chk("midrst_idle", {31'h0, out_valid}, 0);
        send("post_rst", 16'h0001, 8'h38, 1'b0, 18);   drain("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
